// File: rtl/rvfi_chk_pkg.sv
// rtl/rvfi_chk_pkg.sv - shared types, constants and helpers for the RVFI retirement checkers
package rvfi_chk_pkg;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        ERR
    } state_t;

    typedef enum logic [2:0] {
        E_NONE    = 3'd0,
        E_ORDER   = 3'd1,
        E_CHAIN   = 3'd2,
        E_ILLEGAL = 3'd3,
        E_ALIGN   = 3'd4,
        E_TARGET  = 3'd5
    } err_code_t;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    function automatic logic [31:0] b_imm(input logic [31:0] insn);
        return {{19{insn[31]}}, insn[31], insn[7], insn[30:25], insn[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/branch_eval.sv
// rtl/branch_eval.sv - combinational B-type condition evaluation
module branch_eval (
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    input  logic [2:0]  funct3,
    output logic        taken,
    output logic        illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = (rs1 == rs2);
            3'b001:  taken = (rs1 != rs2);
            3'b100:  taken = ($signed(rs1) < $signed(rs2));
            3'b101:  taken = ($signed(rs1) >= $signed(rs2));
            3'b110:  taken = (rs1 < rs2);
            3'b111:  taken = (rs1 >= rs2);
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/rvfi_branch_monitor.sv
// rtl/rvfi_branch_monitor.sv - RVFI retirement checker: branch outcomes, PC chain, order monotonicity
module rvfi_branch_monitor
    import rvfi_chk_pkg::*;
#(
    parameter int          CNT_W    = 16,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             rvfi_valid,
    input  logic [63:0]      rvfi_order,
    input  logic [31:0]      rvfi_insn,
    input  logic             rvfi_trap,
    input  logic [31:0]      rvfi_rs1_rdata,
    input  logic [31:0]      rvfi_rs2_rdata,
    input  logic [31:0]      rvfi_pc_rdata,
    input  logic [31:0]      rvfi_pc_wdata,
    output logic             o_err,
    output logic [2:0]       o_err_code,
    output logic [63:0]      o_err_order,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_taken_cnt,
    output logic             o_busy
);

    state_t      state, state_d;
    err_code_t   code_d, err_code_q;
    logic [31:0] exp_pc;
    logic [63:0] exp_ord;
    logic        skip_ord;

    logic        taken, illegal;
    logic        is_branch, br_chk, tracking;
    logic        ord_bad, chain_bad, ill_bad, align_bad, tgt_bad;
    logic [31:0] target, fall, next_pc;
    logic        unused_insn_bits;

    assign unused_insn_bits = ^rvfi_insn[24:15];

    branch_eval u_branch_eval (
        .rs1     (rvfi_rs1_rdata),
        .rs2     (rvfi_rs2_rdata),
        .funct3  (rvfi_insn[14:12]),
        .taken   (taken),
        .illegal (illegal)
    );

    assign is_branch = (rvfi_insn[6:0] == OP_BRANCH);
    assign br_chk    = is_branch && !rvfi_trap;
    assign tracking  = (state == TRACK);
    assign target    = rvfi_pc_rdata + b_imm(rvfi_insn);
    assign fall      = rvfi_pc_rdata + 32'd4;
    assign next_pc   = taken ? target : fall;

    // Chain and order are only meaningful once a reference PC is held.
    assign ord_bad   = tracking && !skip_ord && (rvfi_order != exp_ord);
    assign chain_bad = tracking && (rvfi_pc_rdata != exp_pc);
    assign ill_bad   = br_chk && illegal;
    assign align_bad = br_chk && taken && (target[1:0] != 2'b00);
    assign tgt_bad   = br_chk && !illegal && (rvfi_pc_wdata != next_pc);

    always_comb begin
        code_d = E_NONE;
        if (ord_bad)        code_d = E_ORDER;
        else if (chain_bad) code_d = E_CHAIN;
        else if (ill_bad)   code_d = E_ILLEGAL;
        else if (align_bad) code_d = E_ALIGN;
        else if (tgt_bad)   code_d = E_TARGET;
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE, TRACK: begin
                if (rvfi_valid) begin
                    if (code_d != E_NONE) state_d = ERR;
                    else if (rvfi_trap)   state_d = IDLE;
                    else                  state_d = TRACK;
                end
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) state <= TRACK;
        else       state <= state_d;
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            exp_pc      <= RESET_PC;
            exp_ord     <= 64'd0;
            skip_ord    <= 1'b1;
            o_err       <= 1'b0;
            err_code_q  <= E_NONE;
            o_err_order <= 64'd0;
            o_br_cnt    <= '0;
            o_taken_cnt <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_busy <= (state_d == TRACK);
            if (rvfi_valid && state != ERR) begin
                if (code_d != E_NONE) begin
                    o_err       <= 1'b1;
                    err_code_q  <= code_d;
                    o_err_order <= rvfi_order;
                end else begin
                    exp_pc   <= rvfi_pc_wdata;
                    exp_ord  <= rvfi_order + 64'd1;
                    skip_ord <= 1'b0;
                    // Both counters saturate at the same value, so taken never exceeds total.
                    if (br_chk && !illegal) begin
                        if (o_br_cnt != {CNT_W{1'b1}})
                            o_br_cnt <= o_br_cnt + CNT_W'(1);
                        if (taken && o_taken_cnt != {CNT_W{1'b1}})
                            o_taken_cnt <= o_taken_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    assign o_err_code = err_code_q;

endmodule

// File: tb/tb_rvfi_branch_monitor.sv
// tb/tb_rvfi_branch_monitor.sv - directed vector bench for rvfi_branch_monitor
module tb_rvfi_branch_monitor;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             i_rst = 1'b1;
    logic             rvfi_valid = 1'b0;
    logic [63:0]      rvfi_order = 64'd0;
    logic [31:0]      rvfi_insn = 32'h13;
    logic             rvfi_trap = 1'b0;
    logic [31:0]      rvfi_rs1_rdata = 32'd0;
    logic [31:0]      rvfi_rs2_rdata = 32'd0;
    logic [31:0]      rvfi_pc_rdata = 32'd0;
    logic [31:0]      rvfi_pc_wdata = 32'd0;
    logic             o_err;
    logic [2:0]       o_err_code;
    logic [63:0]      o_err_order;
    logic [CNT_W-1:0] o_br_cnt;
    logic [CNT_W-1:0] o_taken_cnt;
    logic             o_busy;

    rvfi_branch_monitor #(.CNT_W(CNT_W), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .i_rst          (i_rst),
        .rvfi_valid     (rvfi_valid),
        .rvfi_order     (rvfi_order),
        .rvfi_insn      (rvfi_insn),
        .rvfi_trap      (rvfi_trap),
        .rvfi_rs1_rdata (rvfi_rs1_rdata),
        .rvfi_rs2_rdata (rvfi_rs2_rdata),
        .rvfi_pc_rdata  (rvfi_pc_rdata),
        .rvfi_pc_wdata  (rvfi_pc_wdata),
        .o_err          (o_err),
        .o_err_code     (o_err_code),
        .o_err_order    (o_err_order),
        .o_br_cnt       (o_br_cnt),
        .o_taken_cnt    (o_taken_cnt),
        .o_busy         (o_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        valid;
        logic [63:0] ord;
        logic [31:0] insn;
        logic        trap;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pcr;
        logic [31:0] pcw;
        logic        err;
        logic [2:0]  code;
        logic [63:0] eord;
        logic [15:0] br;
        logic [15:0] tk;
        logic        busy;
        logic        cnt_x;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] M1  = 32'hFFFF_FFFF;

    function automatic logic [31:0] mk_b(input logic [2:0] f3, input logic [12:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction

    task automatic add(input logic rst, input logic valid, input logic [63:0] ord,
                       input logic [31:0] insn, input logic trap, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] pcr, input logic [31:0] pcw,
                       input logic err, input logic [2:0] code, input logic [63:0] eord,
                       input logic [15:0] br, input logic [15:0] tk, input logic busy,
                       input logic cnt_x);
        vec_t v;
        v.rst = rst; v.valid = valid; v.ord = ord; v.insn = insn; v.trap = trap;
        v.rs1 = rs1; v.rs2 = rs2; v.pcr = pcr; v.pcw = pcw; v.err = err; v.code = code;
        v.eord = eord; v.br = br; v.tk = tk; v.busy = busy; v.cnt_x = cnt_x;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic valid, input logic [63:0] ord,
                         input logic [31:0] insn, input logic trap, input logic [31:0] rs1,
                         input logic [31:0] rs2, input logic [31:0] pcr, input logic [31:0] pcw);
        @(negedge clk);
        i_rst = rst; rvfi_valid = valid; rvfi_order = ord; rvfi_insn = insn;
        rvfi_trap = trap; rvfi_rs1_rdata = rs1; rvfi_rs2_rdata = rs2;
        rvfi_pc_rdata = pcr; rvfi_pc_wdata = pcw;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //  rst v  ord insn                 trp rs1 rs2 pcr       pcw        err code eord br tk busy x
        add(1, 1, 0,  NOP,                  0, 0,  0,  32'h0,    32'h0,     0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 0,  NOP,                  0, 0,  0,  32'h0,    32'h100,   0, 0, 0,  0, 0, 1, 0);
        add(0, 1, 1,  mk_b(3'b000, 13'd16), 0, 5,  5,  32'h100,  32'h110,   0, 0, 0,  1, 1, 1, 0);
        add(0, 0, 77, mk_b(3'b001, 13'd4),  0, 1,  2,  32'h999,  32'h0,     0, 0, 0,  1, 1, 1, 0);
        add(0, 1, 2,  mk_b(3'b110, -13'sd8), 0, M1, 1, 32'h110,  32'h114,   0, 0, 0,  2, 1, 1, 0);
        add(0, 1, 3,  mk_b(3'b001, -13'sd20), 0, 1, 2, 32'h114,  32'h100,   0, 0, 0,  3, 2, 1, 0);
        add(0, 1, 4,  mk_b(3'b101, 13'd8),  0, M1, 1,  32'h100,  32'h104,   0, 0, 0,  4, 2, 1, 0);
        add(0, 1, 5,  mk_b(3'b111, 13'd8),  0, M1, 1,  32'h104,  32'h10C,   0, 0, 0,  5, 3, 1, 0);
        add(0, 1, 6,  mk_b(3'b010, 13'd8),  1, 0,  0,  32'h10C,  32'h800,   0, 0, 0,  5, 3, 0, 0);
        add(0, 1, 7,  NOP,                  0, 0,  0,  32'h4000, 32'h4004,  0, 0, 0,  5, 3, 1, 0);
        add(0, 1, 8,  NOP,                  0, 0,  0,  32'h4004, 32'h200,   0, 0, 0,  5, 3, 1, 0);
        add(0, 1, 9,  mk_b(3'b100, -13'sd8), 0, M1, 1, 32'h200,  32'h204,   1, 5, 9,  0, 0, 0, 1);
        add(0, 1, 10, NOP,                  0, 0,  0,  32'h204,  32'h208,   1, 5, 9,  0, 0, 0, 1);
        add(1, 1, 0,  NOP,                  0, 0,  0,  32'h0,    32'h4,     0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 3,  NOP,                  0, 0,  0,  32'h0,    32'h20,    0, 0, 0,  0, 0, 1, 0);
        add(0, 1, 5,  NOP,                  0, 0,  0,  32'h20,   32'h24,    1, 1, 5,  0, 0, 0, 1);
        add(1, 0, 0,  NOP,                  0, 0,  0,  32'h0,    32'h0,     0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 3,  NOP,                  0, 0,  0,  32'h0,    32'h40,    0, 0, 0,  0, 0, 1, 0);
        add(0, 1, 4,  NOP,                  0, 0,  0,  32'h44,   32'h48,    1, 2, 4,  0, 0, 0, 1);
        add(1, 0, 0,  NOP,                  0, 0,  0,  32'h0,    32'h0,     0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 0,  mk_b(3'b011, 13'd8),  0, 0,  0,  32'h8,    32'hC,     1, 2, 0,  0, 0, 0, 1);
        add(1, 0, 0,  NOP,                  0, 0,  0,  32'h0,    32'h0,     0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 0,  mk_b(3'b000, 13'd6),  0, 0,  0,  32'h0,    32'h4,     1, 4, 0,  0, 0, 0, 1);
        add(1, 0, 0,  NOP,                  0, 0,  0,  32'h0,    32'h0,     0, 0, 0,  0, 0, 0, 0);
        add(0, 1, 0,  NOP,                  0, 0,  0,  32'h0,    32'h10,    0, 0, 0,  0, 0, 1, 0);
        add(0, 1, 2,  mk_b(3'b010, 13'd8),  0, 0,  0,  32'h14,   32'h18,    1, 1, 2,  0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].ord, vecs[i].insn, vecs[i].trap,
                  vecs[i].rs1, vecs[i].rs2, vecs[i].pcr, vecs[i].pcw);
            check($sformatf("v%0d err", i), 64'(o_err), 64'(vecs[i].err));
            check($sformatf("v%0d code", i), 64'(o_err_code), 64'(vecs[i].code));
            check($sformatf("v%0d err_order", i), o_err_order, vecs[i].eord);
            check($sformatf("v%0d busy", i), 64'(o_busy), 64'(vecs[i].busy));
            if (!vecs[i].cnt_x) begin
                check($sformatf("v%0d br_cnt", i), 64'(o_br_cnt), 64'(vecs[i].br));
                check($sformatf("v%0d taken_cnt", i), 64'(o_taken_cnt), 64'(vecs[i].tk));
            end
        end

        // Saturation: 2^CNT_W+3 taken self-loop branches at pc 0.
        drive(1, 0, 0, NOP, 0, 0, 0, 0, 0);
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            drive(0, 1, 64'(i), mk_b(3'b000, 13'd0), 0, 7, 7, 32'h0, 32'h0);
        check("sat err", 64'(o_err), 64'd0);
        check("sat br_cnt", 64'(o_br_cnt), 64'hFFFF);
        check("sat taken_cnt", 64'(o_taken_cnt), 64'hFFFF);

        drive(0, 1, 64'd999999, NOP, 0, 0, 0, 32'h0, 32'h4);
        check("forced err", 64'(o_err), 64'd1);
        check("forced code", 64'(o_err_code), 64'd1);
        check("forced order", o_err_order, 64'd999999);

        drive(1, 1, 64'd5, NOP, 0, 0, 0, 32'h0, 32'h4);
        check("rst err", 64'(o_err), 64'd0);
        check("rst code", 64'(o_err_code), 64'd0);
        check("rst order", o_err_order, 64'd0);
        check("rst br_cnt", 64'(o_br_cnt), 64'd0);
        check("rst taken_cnt", 64'(o_taken_cnt), 64'd0);
        check("rst busy", 64'(o_busy), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/rvfi_branch_monitor.md
# rvfi_branch_monitor

Synthesizable retirement-stream checker that sits directly downstream of `serv_top`'s RVFI port, beside the formal property module. It consumes every retired instruction, recomputes conditional-branch outcomes for all six B-type funct3 codes, and checks PC-chain continuity and `rvfi_order` monotonicity across retirements. Any violation is latched as a sticky error with a code and the offending order number. The block works in simulation and as a bound formal target.

## Interface
Parameters:
- `CNT_W`, 16, width of the saturating branch and taken counters.
- `RESET_PC`, 32'h0, expected `rvfi_pc_rdata` of the first retirement after reset.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `i_rst`  in  1  reset; **one clock; reset is synchronous and active-high**.
- `rvfi_valid`  in  1  retirement strobe.
- `rvfi_order`  in  64  retirement index.
- `rvfi_insn`  in  32  retired instruction.
- `rvfi_trap`  in  1  retirement trapped.
- `rvfi_rs1_rdata`, `rvfi_rs2_rdata`  in  32 each  operand values.
- `rvfi_pc_rdata`, `rvfi_pc_wdata`  in  32 each  PC of this instruction and next PC.
- `o_err`  out  1  sticky error flag.
- `o_err_code`  out  3  first error cause.
- `o_err_order`  out  64  `rvfi_order` of the first failing retirement.
- `o_br_cnt`  out  CNT_W  non-trapping branches retired.
- `o_taken_cnt`  out  CNT_W  taken branches retired.
- `o_busy`  out  1  high in TRACK.

## Operation
- State machine with states IDLE, TRACK and ERR.
  - IDLE: no reference PC is held. A valid retirement skips the chain and order checks, stores `exp_pc <= pc_wdata` and `exp_ord <= order+1`, and moves to TRACK.
  - TRACK: every valid retirement runs all checks. On pass, `exp_pc` and `exp_ord` update as in IDLE.
  - ERR: terminal. Only `i_rst` leaves it.
- After reset, the first retirement is checked against `RESET_PC` for chain only. For this, reset loads `exp_pc = RESET_PC`, and the state enters TRACK with order checking suppressed for one retirement.
- Trap: a retirement with `rvfi_trap=1` runs only the chain and order checks. It skips the branch checks and does not count. It sends the state to IDLE, because the trap vector is not predictable.
- A branch is `insn[6:0]==7'b1100011`. Branch outcome by funct3:
  - 000: rs1==rs2
  - 001: rs1!=rs2
  - 100: signed rs1<rs2
  - 101: signed rs1>=rs2
  - 110: unsigned rs1<rs2
  - 111: unsigned rs1>=rs2
- Immediate: sign-extended {insn[31],insn[7],insn[30:25],insn[11:8],1'b0}. Target = pc_rdata+imm, computed modulo 2^32. Fall-through = pc_rdata+4, wrapping at 2^32.
- Error codes, listed in priority order (lowest number wins on simultaneous failures):
  - 1 ORDER: order != exp_ord.
  - 2 CHAIN: pc_rdata != exp_pc.
  - 3 ILLEGAL: branch with funct3 010/011 and no trap.
  - 4 ALIGN: taken branch with target[1:0]!=0 and no trap.
  - 5 TARGET: pc_wdata != the expected next PC.
  - 0 means no error.
- Counters saturate at all-ones and never wrap. `o_taken_cnt` <= `o_br_cnt` always.

## Timing
- Every output is registered. Results for a retirement at edge N are visible after edge N+1, i.e. a 1-cycle latency.
- Back-to-back valid retirements are supported every cycle, with no stall input.
- Reset values: `o_err=0`, `o_err_code=0`, `o_err_order=0`, both counters 0, `o_busy=0`. Internally `exp_pc=RESET_PC` and `exp_ord=0`.
- When `i_rst` and `rvfi_valid` are high in the same cycle, reset wins and the retirement is ignored.
- Reset asserted in ERR clears everything on the next edge.
- In ERR, `o_err_code` and `o_err_order` hold their values. Counters freeze.
- `rvfi_valid=0`: no state change.

## Structure
- Package `rvfi_chk_pkg`:
  - `typedef enum logic[1:0] {IDLE,TRACK,ERR}`.
  - `typedef enum logic[2:0]` for the error codes.
  - Opcode constant `OP_BRANCH`.
  - Function `b_imm(insn)`.
- Sub-module `branch_eval` (combinational): inputs are the operands and funct3, outputs are `taken` and `illegal`. It is reused by the later JAL/JALR checker.

## Test plan
- BEQ at pc 0x100, imm +16, rs1=rs2=5, pc_wdata 0x110 -> no error, br_cnt=1, taken_cnt=1.
- BLT with rs1=0xFFFFFFFF, rs2=1, imm −8, pc 0x200, pc_wdata 0x204 -> err=1, code=5, err_order = that order, one cycle later.
- BLTU with the same operands, pc_wdata 0x204 -> no error, taken_cnt unchanged.
- Two retirements with orders 3 and 5 -> code 1. Orders 3 and 4 where the second pc_rdata ≠ the first pc_wdata -> code 2.
- Trap retirement followed by a retirement at an arbitrary PC -> no CHAIN error. Next in-order retirement checked normally.
- Force an error, then assert `i_rst` with `rvfi_valid` high -> all outputs 0 next cycle. Drive 2^CNT_W+3 taken branches -> counters hold all-ones.
